// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the stream round-robin arbiter family.
package stream_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int unsigned rr_id_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request strictly after last_grant,
// wrapping modulo NumReq.
module rr_priority_picker
  import stream_arb_pkg::*;
#(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned IdWidth = rr_id_width(NumReq)
) (
  input  logic [NumReq-1:0]  req,
  input  logic [IdWidth-1:0] last_grant,
  output logic [IdWidth-1:0] win_id,
  output logic               any_req
);

  logic [IdWidth-1:0] idx;
  logic               found;

  always_comb begin
    win_id  = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      idx = IdWidth'((32'(last_grant) + i) % NumReq);
      if (!found && req[idx]) begin
        win_id = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin merge of NumReq ready/valid byte streams with burst-limited grants.
// Optional last_o burst-end flag enabled by defining STREAM_RR_ARBITER_LAST_EN.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int unsigned Width    = 8,
  parameter int unsigned NumReq   = 4,
  parameter int unsigned BurstLen = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumReq*Width-1:0]           data_i,
  input  logic [NumReq-1:0]                 valid_i,
  output logic [NumReq-1:0]                 ready_o,
  output logic [Width-1:0]                  data_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [rr_id_width(NumReq)-1:0]    grant_id_o,
  output logic                              busy_o
`ifdef STREAM_RR_ARBITER_LAST_EN
  ,
  output logic                              last_o
`endif
);

  localparam int unsigned IdWidth  = rr_id_width(NumReq);
  localparam int unsigned CntWidth = $clog2(BurstLen + 1);
  localparam logic [CntWidth-1:0] LastBeat = CntWidth'(BurstLen - 1);

  arb_state_e          state;
  logic [IdWidth-1:0]  grant_id;
  logic [IdWidth-1:0]  last_grant;
  logic [CntWidth-1:0] beat_cnt;

  logic [IdWidth-1:0]  win_id;
  logic                any_req;
  logic [Width-1:0]    src_data [NumReq];
  logic                active;
  logic                out_fire;

  rr_priority_picker #(
    .NumReq  (NumReq),
    .IdWidth (IdWidth)
  ) u_picker (
    .req        (valid_i),
    .last_grant (last_grant),
    .win_id     (win_id),
    .any_req    (any_req)
  );

  always_comb begin
    for (int unsigned k = 0; k < NumReq; k++) begin
      src_data[k] = data_i[k*Width +: Width];
    end
  end

  // Handshakes are masked while reset is asserted so a beat in flight at a
  // reset edge is never acknowledged to its source.
  assign active   = (state == GRANT) && rst_ni;
  assign out_fire = valid_o && ready_i;

  always_comb begin
    data_o  = '0;
    valid_o = 1'b0;
    ready_o = '0;
    if (active) begin
      data_o            = src_data[grant_id];
      valid_o           = valid_i[grant_id];
      ready_o[grant_id] = ready_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      grant_id   <= '0;
      beat_cnt   <= '0;
      last_grant <= IdWidth'(NumReq - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= win_id;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if ((out_fire && beat_cnt == LastBeat) || !valid_i[grant_id]) begin
            state      <= IDLE;
            last_grant <= grant_id;
          end else if (out_fire) begin
            beat_cnt <= beat_cnt + CntWidth'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o     = (state == GRANT);
  assign grant_id_o = grant_id;

`ifdef STREAM_RR_ARBITER_LAST_EN
  assign last_o = valid_o && (beat_cnt == LastBeat);
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: per-source expected queues plus a
// transaction-level arbitration model.
module tb_stream_rr_arbiter;

  localparam int W = 8;
  localparam int N = 4;
  localparam int B = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] data_i = '0;
  logic [N-1:0]   valid_i = '0;
  logic [N-1:0]   ready_o;
  logic [W-1:0]   data_o;
  logic           valid_o;
  logic           ready_i = 1'b0;
  logic [1:0]     grant_id_o;
  logic           busy_o;
`ifdef STREAM_RR_ARBITER_LAST_EN
  logic           last_o;
`endif

  always #5 clk = ~clk;

  stream_rr_arbiter #(
    .Width    (W),
    .NumReq   (N),
    .BurstLen (B)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .grant_id_o (grant_id_o),
    .busy_o     (busy_o)
`ifdef STREAM_RR_ARBITER_LAST_EN
    ,
    .last_o     (last_o)
`endif
  );

  int total = 0;
  int bad = 0;

  logic [7:0] src_q [N][$];
  logic [7:0] exp_q [N][$];
  int         seq [N];
  int         grant_log [$];
  int         fire_cnt [N];

  int         p_valid = 100;
  int         p_ready = 100;
  bit         started = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input int k, input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = {2'(k), 6'(seq[k])};
      seq[k]++;
      src_q[k].push_back(b);
      exp_q[k].push_back(b);
    end
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++)
      if (src_q[k].size() != 0 || exp_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_empty(input string name, input int budget);
    int c = 0;
    while (!all_empty() && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (!all_empty()) begin
      total++;
      bad++;
      $display("FAIL %s: queues not drained after %0d cycles", name, budget);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Source driver: holds each beat until the arbiter accepts it.
  logic [N-1:0] acc;
  initial begin
    forever begin
      @(negedge clk);
      acc = valid_i & ready_o;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k]) begin
          void'(src_q[k].pop_front());
          valid_i[k] = 1'b0;
        end
        if (!valid_i[k] && src_q[k].size() > 0 && $urandom_range(99) < p_valid)
          valid_i[k] = 1'b1;
        if (valid_i[k]) data_i[k*W +: W] = src_q[k][0];
        else            data_i[k*W +: W] = 8'($urandom);
      end
      ready_i = ($urandom_range(99) < p_ready);
    end
  end

  // Reference model: who owns the output, how many beats it has moved,
  // and who was served last.
  bit m_busy = 1'b0;
  int m_own = 0;
  int m_beats = 0;
  int m_last = N - 1;

  initial begin
    bit         act, fire, exp_valid;
    logic [N-1:0] exp_ready;
    int         c;
    forever begin
      @(negedge clk);
      if (started) begin
        act       = m_busy && rst_n;
        exp_valid = act && valid_i[m_own];
        exp_ready = act ? (N'(ready_i) << m_own) : '0;
        fire      = exp_valid && ready_i;

        chk("busy", busy_o, m_busy);
        chk("valid_o", valid_o, exp_valid);
        chk("ready_o", ready_o, exp_ready);
        if (m_busy) chk("grant_id", grant_id_o, m_own);
        if (!act) chk("idle_data", data_o, 0);
        else if (exp_valid) begin
          if (exp_q[m_own].size() == 0) chk("data_underflow", data_o, -1);
          else chk("data_o", data_o, exp_q[m_own][0]);
        end
`ifdef STREAM_RR_ARBITER_LAST_EN
        chk("last_o", last_o, exp_valid && (m_beats == B - 1));
`endif
        if (fire && exp_q[m_own].size() > 0) begin
          void'(exp_q[m_own].pop_front());
          fire_cnt[m_own]++;
        end

        if (!rst_n) begin
          m_busy  = 1'b0;
          m_last  = N - 1;
          m_beats = 0;
        end else if (m_busy) begin
          if (fire) m_beats++;
          if ((fire && m_beats == B) || !valid_i[m_own]) begin
            m_busy = 1'b0;
            m_last = m_own;
          end
        end else if (valid_i != '0) begin
          for (int i = 1; i <= N; i++) begin
            c = (m_last + i) % N;
            if (valid_i[c]) break;
          end
          m_own   = c;
          m_busy  = 1'b1;
          m_beats = 0;
          grant_log.push_back(c);
        end
      end
    end
  end

  initial begin
    int exp_log [$];
    logic [7:0] first_b;

    for (int k = 0; k < N; k++) begin
      seq[k] = 0;
      fire_cnt[k] = 0;
    end

    // Reset held with every source requesting, then fairness under full load.
    p_valid = 100;
    p_ready = 100;
    for (int k = 0; k < N; k++) load(k, 8);
    @(posedge clk);
    #1 started = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_ready_o", ready_o, 0);
    chk("rst_busy", busy_o, 0);
    grant_log.delete();
    rst_n = 1'b1;
    wait_empty("fairness", 200);
    exp_log = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk("fair_grants", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk("fair_order", grant_log[i], exp_log[i]);

    // Drain-terminated grant on a lone source.
    grant_log.delete();
    fire_cnt[2] = 0;
    load(2, 3);
    wait_empty("drain", 50);
    chk("drain_grants", grant_log.size(), 1);
    if (grant_log.size() > 0) chk("drain_id", grant_log[0], 2);
    chk("drain_beats", fire_cnt[2], 3);

    // Backpressure: grant held with stable data, then bursts complete.
    grant_log.delete();
    p_ready = 0;
    first_b = {2'd1, 6'(seq[1])};
    load(1, 20);
    repeat (12) @(posedge clk);
    #1;
    chk("bp_busy", busy_o, 1);
    chk("bp_gid", grant_id_o, 1);
    chk("bp_data", data_o, first_b);
    chk("bp_ready", ready_o, 0);
    p_ready = 100;
    wait_empty("backpressure", 200);
    chk("bp_grants", grant_log.size(), 5);

    // Rotation skip: after serving 0, the 0/3 contest goes to 3 first.
    load(0, 1);
    wait_empty("rot_setup", 50);
    grant_log.delete();
    load(0, 4);
    load(3, 4);
    wait_empty("rotation", 100);
    exp_log = '{3, 0};
    chk("rot_grants", grant_log.size(), 2);
    for (int i = 0; i < 2 && i < grant_log.size(); i++)
      chk("rot_order", grant_log[i], exp_log[i]);

    // Randomised traffic with a reset pulse in the middle.
    p_valid = 60;
    p_ready = 70;
    for (int it = 0; it < 600; it++) begin
      for (int k = 0; k < N; k++)
        if (src_q[k].size() < 3 && $urandom_range(99) < 10)
          load(k, $urandom_range(1, 9));
      if (it == 300) rst_n = 1'b0;
      if (it == 302) rst_n = 1'b1;
      @(posedge clk);
      #1;
    end
    wait_empty("random", 2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
